// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM state encodings for the sequential ALU.
// Opcode values match the combinational datapath ALU so decode logic is reusable.
package alu_seq_pkg;

    typedef logic [4:0] opcode_t;
    typedef logic [1:0] state_t;

    localparam opcode_t OpAdd   = 5'd0;
    localparam opcode_t OpSub   = 5'd1;
    localparam opcode_t OpMul   = 5'd2;
    localparam opcode_t OpDiv   = 5'd3;
    localparam opcode_t OpInc   = 5'd4;
    localparam opcode_t OpDec   = 5'd5;
    localparam opcode_t OpAnd   = 5'd6;
    localparam opcode_t OpOr    = 5'd7;
    localparam opcode_t OpXor   = 5'd8;
    localparam opcode_t OpEnc   = 5'd9;
    localparam opcode_t OpDecry = 5'd10;

    localparam state_t StIdle = 2'd0;
    localparam state_t StBusy = 2'd1;
    localparam state_t StDone = 2'd2;

    function automatic logic op_is_iterative(opcode_t op);
        return (op == OpMul) || (op == OpDiv);
    endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// done_o marks the final iteration; lo_o/hi_o carry that iteration's result.
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    logic             busy_q;
    logic             div_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] opb_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] acc_step;
    logic [WIDTH-1:0] sh_step;

    // MUL: {acc, sh} holds the running product, multiplier bits leave sh from the LSB.
    // DIV: acc is the partial remainder, dividend bits leave sh from the MSB while
    //      quotient bits enter at the LSB.
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_q, sh_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opb_q};
        div_rem   = div_shift[WIDTH-1:0] - opb_q;
        if (div_q) begin
            acc_step = div_ge ? div_rem : div_shift[WIDTH-1:0];
            sh_step  = {sh_q[WIDTH-2:0], div_ge};
        end else begin
            acc_step = mul_sum[WIDTH:1];
            sh_step  = {mul_sum[0], sh_q[WIDTH-1:1]};
        end
    end

    assign done_o = busy_q && (cnt_q == LastCnt);
    assign lo_o   = sh_step;
    assign hi_o   = acc_step;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            sh_q   <= '0;
            opb_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            div_q  <= div_i;
            cnt_q  <= '0;
            acc_q  <= '0;
            sh_q   <= a_i;
            opb_q  <= b_i;
        end else if (busy_q) begin
            acc_q <= acc_step;
            sh_q  <= sh_step;
            if (done_o) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: control FSM, single-cycle datapath, flags and
// output register; MUL/DIV are delegated to alu_seq_iter.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned     WIDTH = 32,
    parameter logic [WIDTH-1:0] KEY  = WIDTH'(32'h32BAC819)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [4:0]       alu_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             div_zero
);

    localparam int unsigned Msb = WIDTH - 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             dz_q, dz_d;
    logic             is_div_q, is_div_d;

    logic             accept;
    logic             launch;
    logic             iter_start;
    logic             iter_done;
    logic [WIDTH-1:0] iter_lo;
    logic [WIDTH-1:0] iter_hi;

    logic [WIDTH-1:0] add_b;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH-1:0] fast_res;
    logic             fast_z, fast_c, fast_v, fast_dz;
    logic             fast_known;
    logic             fast_iter;

    // in_ready depends only on state, out_ready and rst, never on in_valid.
    assign in_ready  = !rst && ((state_q == StIdle) || ((state_q == StDone) && out_ready));
    assign out_valid = (state_q == StDone);
    assign accept    = in_valid && in_ready;

    assign out      = out_q;
    assign zero     = zero_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;
    assign div_zero = dz_q;

    // Single-cycle results; also decides whether the op needs the iterative unit.
    always_comb begin
        add_b      = '0;
        sum_w      = '0;
        fast_res   = '0;
        fast_c     = 1'b0;
        fast_v     = 1'b0;
        fast_dz    = 1'b0;
        fast_known = 1'b1;
        fast_iter  = op_is_iterative(alu_ctrl) && !((alu_ctrl == OpDiv) && (in2 == '0));
        case (alu_ctrl)
            OpAdd, OpInc: begin
                add_b    = (alu_ctrl == OpInc) ? WIDTH'(1) : in2;
                sum_w    = {1'b0, in1} + {1'b0, add_b};
                fast_res = sum_w[WIDTH-1:0];
                fast_c   = sum_w[WIDTH];
                fast_v   = (in1[Msb] == add_b[Msb]) && (fast_res[Msb] != in1[Msb]);
            end
            OpSub, OpDec: begin
                add_b    = (alu_ctrl == OpDec) ? WIDTH'(1) : in2;
                fast_res = in1 - add_b;
                fast_c   = in1 < add_b;
                fast_v   = (in1[Msb] != add_b[Msb]) && (fast_res[Msb] != in1[Msb]);
            end
            OpAnd:          fast_res = in1 & in2;
            OpOr:           fast_res = in1 | in2;
            OpXor:          fast_res = in1 ^ in2;
            OpEnc, OpDecry: fast_res = in1 ^ KEY;
            OpMul:          fast_res = '0;
            OpDiv: begin
                if (in2 == '0) begin
                    fast_res = '1;
                    fast_dz  = 1'b1;
                end
            end
            default:        fast_known = 1'b0;
        endcase
        fast_z = fast_known && (fast_res == '0);
    end

    always_comb begin
        state_d    = state_q;
        out_d      = out_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        ovf_d      = ovf_q;
        dz_d       = dz_q;
        is_div_d   = is_div_q;
        launch     = 1'b0;
        iter_start = 1'b0;

        case (state_q)
            StIdle: launch = accept;
            StBusy: begin
                if (iter_done) begin
                    state_d = StDone;
                    out_d   = iter_lo;
                    zero_d  = (iter_lo == '0);
                    carry_d = !is_div_q && (iter_hi != '0);
                    ovf_d   = 1'b0;
                    dz_d    = 1'b0;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                    launch  = accept;
                end
            end
            default: state_d = StIdle;
        endcase

        if (launch) begin
            if (fast_iter) begin
                state_d    = StBusy;
                iter_start = 1'b1;
                is_div_d   = (alu_ctrl == OpDiv);
            end else begin
                state_d = StDone;
                out_d   = fast_res;
                zero_d  = fast_z;
                carry_d = fast_c;
                ovf_d   = fast_v;
                dz_d    = fast_dz;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            out_q    <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
            is_div_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            dz_q     <= dz_d;
            is_div_q <= is_div_d;
        end
    end

    alu_seq_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (iter_start),
        .div_i   (alu_ctrl == OpDiv),
        .a_i     (in1),
        .b_i     (in2),
        .done_o  (iter_done),
        .lo_o    (iter_lo),
        .hi_o    (iter_hi)
    );

endmodule

// File: tb/tb_alu_seq.sv
// Randomised bench for alu_seq at WIDTH=32 and WIDTH=8 against an arithmetic model.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic clk, rst;

    logic        in_valid32, in_ready32, out_valid32, out_ready32;
    logic        zero32, carry32, ovf32, dz32;
    logic [31:0] in1_32, in2_32, out32;
    logic [4:0]  op32;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic        zero8, carry8, ovf8, dz8;
    logic [7:0]  in1_8, in2_8, out8;
    logic [4:0]  op8;

    bit          sel8;
    logic        tb_valid, tb_ordy;
    logic [4:0]  tb_op;
    logic [63:0] tb_a, tb_b;

    logic [63:0] cur_out;
    logic        cur_valid, cur_ready, cur_z, cur_c, cur_v, cur_dz;

    int n_total = 0;
    int n_bad   = 0;

    longint unsigned obs_res;
    bit obs_z, obs_c, obs_v, obs_dz;
    int obs_lat;

    alu_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .in1(in1_32), .in2(in2_32), .alu_ctrl(op32), .out_valid(out_valid32),
        .out_ready(out_ready32), .out(out32), .zero(zero32), .carry(carry32),
        .overflow(ovf32), .div_zero(dz32)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .in1(in1_8), .in2(in2_8), .alu_ctrl(op8), .out_valid(out_valid8),
        .out_ready(out_ready8), .out(out8), .zero(zero8), .carry(carry8),
        .overflow(ovf8), .div_zero(dz8)
    );

    assign in_valid32  = !sel8 && tb_valid;
    assign out_ready32 = sel8 ? 1'b1 : tb_ordy;
    assign in1_32      = tb_a[31:0];
    assign in2_32      = tb_b[31:0];
    assign op32        = tb_op;
    assign in_valid8   = sel8 && tb_valid;
    assign out_ready8  = sel8 ? tb_ordy : 1'b1;
    assign in1_8       = tb_a[7:0];
    assign in2_8       = tb_b[7:0];
    assign op8         = tb_op;

    assign cur_out   = sel8 ? {56'd0, out8} : {32'd0, out32};
    assign cur_valid = sel8 ? out_valid8 : out_valid32;
    assign cur_ready = sel8 ? in_ready8 : in_ready32;
    assign cur_z     = sel8 ? zero8 : zero32;
    assign cur_c     = sel8 ? carry8 : carry32;
    assign cur_v     = sel8 ? ovf8 : ovf32;
    assign cur_dz    = sel8 ? dz8 : dz32;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference results straight from the arithmetic definition of each op.
    function automatic void model(input int w, input logic [4:0] op,
                                  input longint unsigned a, input longint unsigned b,
                                  output longint unsigned res, output bit z, output bit c,
                                  output bit v, output bit dz, output int lat);
        longint unsigned mask = (64'd1 << w) - 64'd1;
        longint unsigned key  = 64'h32BAC819 & mask;
        longint unsigned bb, s;
        bit known = 1'b1;
        bit sa, sb, sr;
        res = 0; c = 0; v = 0; dz = 0; lat = 1;
        case (op)
            OpAdd, OpInc: begin
                bb = (op == OpInc) ? 64'd1 : b;
                s = a + bb;
                res = s & mask;
                c = (s >> w) != 0;
                sa = a[w-1]; sb = bb[w-1]; sr = res[w-1];
                v = (sa == sb) && (sr != sa);
            end
            OpSub, OpDec: begin
                bb = (op == OpDec) ? 64'd1 : b;
                res = (a - bb) & mask;
                c = a < bb;
                sa = a[w-1]; sb = bb[w-1]; sr = res[w-1];
                v = (sa != sb) && (sr != sa);
            end
            OpAnd: res = a & b;
            OpOr:  res = a | b;
            OpXor: res = a ^ b;
            OpEnc, OpDecry: res = a ^ key;
            OpMul: begin
                s = a * b;
                res = s & mask;
                c = (s >> w) != 0;
                lat = w + 1;
            end
            OpDiv: begin
                if (b == 0) begin
                    res = mask;
                    dz = 1'b1;
                end else begin
                    res = a / b;
                    lat = w + 1;
                end
            end
            default: known = 1'b0;
        endcase
        z = known && (res == 0);
    endfunction

    function automatic longint unsigned rand_opnd(input int w);
        longint unsigned mask = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return mask;
            2: return 64'd1 << (w - 1);
            3: return 64'($urandom_range(0, 15));
            default: return {32'd0, $urandom()} & mask;
        endcase
    endfunction

    // One transaction with out_ready held high; inputs are scrambled after acceptance.
    task automatic run_op(input string tag, input logic [4:0] op,
                          input longint unsigned a, input longint unsigned b);
        longint unsigned er;
        bit ez, ec, ev, edz;
        int elat, k, lat;
        int w = sel8 ? 8 : 32;
        model(w, op, a, b, er, ez, ec, ev, edz, elat);
        @(negedge clk);
        tb_op = op; tb_a = a; tb_b = b; tb_valid = 1'b1; tb_ordy = 1'b1;
        k = 0;
        while (!cur_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check({tag, ".ready"}, 64'(cur_ready), 64'd1);
        @(posedge clk);
        #1;
        tb_valid = 1'b0;
        tb_op = 5'($urandom());
        tb_a = {$urandom(), $urandom()};
        tb_b = {$urandom(), $urandom()};
        lat = 1;
        @(negedge clk);
        while (!cur_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        obs_res = cur_out; obs_z = cur_z; obs_c = cur_c; obs_v = cur_v; obs_dz = cur_dz;
        obs_lat = lat;
        check({tag, ".lat"}, 64'(lat), 64'(elat));
        check({tag, ".out"}, cur_out, er);
        check({tag, ".flags"}, 64'({cur_dz, cur_v, cur_c, cur_z}), 64'({edz, ev, ec, ez}));
    endtask

    task automatic expect_obs(input string tag, input longint unsigned res, input bit z,
                              input bit c, input bit v, input bit dz, input int lat);
        check({tag, ".k_out"}, obs_res, res);
        check({tag, ".k_flags"}, 64'({obs_dz, obs_v, obs_c, obs_z}), 64'({dz, v, c, z}));
        check({tag, ".k_lat"}, 64'(obs_lat), 64'(lat));
    endtask

    initial begin
        logic [4:0] op;
        logic [4:0] one_cyc [9];
        longint unsigned a, b, er, exp_res;
        bit ez, ec, ev, edz;
        int elat, sent, recv, seen;
        longint unsigned q_res[$];
        logic [3:0] q_flg[$];
        logic [3:0] exp_flg;

        one_cyc = '{OpAdd, OpSub, OpInc, OpDec, OpAnd, OpOr, OpXor, OpEnc, OpDecry};
        sel8 = 1'b0; tb_valid = 1'b0; tb_ordy = 1'b1; tb_op = '0; tb_a = '0; tb_b = '0;
        rst = 1'b1;

        // Reset behaviour
        @(negedge clk);
        check("rst.ready32", 64'(in_ready32), 64'd0);
        check("rst.ready8", 64'(in_ready8), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst.valid", 64'(out_valid32), 64'd0);
        check("rst.out", 64'(out32), 64'd0);
        check("rst.flags", 64'({dz32, ovf32, carry32, zero32}), 64'd0);
        rst = 1'b0;
        #1;
        check("rst.ready_after", 64'(in_ready32), 64'd1);

        // Directed WIDTH=32 cases
        run_op("add_wrap", OpAdd, 64'hFFFFFFFF, 64'd1);
        expect_obs("add_wrap", 64'd0, 1, 1, 0, 0, 1);
        run_op("sub_ovf", OpSub, 64'h80000000, 64'd1);
        expect_obs("sub_ovf", 64'h7FFFFFFF, 0, 0, 1, 0, 1);
        run_op("enc0", OpEnc, 64'd0, 64'h1234);
        expect_obs("enc0", 64'h32BAC819, 0, 0, 0, 0, 1);
        run_op("decry", OpDecry, 64'h32BAC819, 64'd0);
        expect_obs("decry", 64'd0, 1, 0, 0, 0, 1);
        run_op("mul_big", OpMul, 64'h10000, 64'h10000);
        expect_obs("mul_big", 64'd0, 1, 1, 0, 0, 33);
        run_op("mul_small", OpMul, 64'd1234, 64'd5678);
        expect_obs("mul_small", 64'd7006652, 0, 0, 0, 0, 33);
        run_op("div", OpDiv, 64'd100, 64'd7);
        expect_obs("div", 64'd14, 0, 0, 0, 0, 33);
        run_op("div0", OpDiv, 64'd5, 64'd0);
        expect_obs("div0", 64'hFFFFFFFF, 0, 0, 0, 1, 1);
        run_op("undef", 5'd31, 64'd0, 64'd0);
        expect_obs("undef", 64'd0, 0, 0, 0, 0, 1);

        // Back-pressure with a queued XOR
        @(negedge clk);
        tb_op = OpAdd; tb_a = 64'd3; tb_b = 64'd4; tb_valid = 1'b1; tb_ordy = 1'b0;
        @(posedge clk);
        #1;
        tb_op = OpXor; tb_a = 64'hF0; tb_b = 64'hFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp.out", cur_out, 64'd7);
            check("bp.valid", 64'(cur_valid), 64'd1);
            check("bp.ready", 64'(cur_ready), 64'd0);
        end
        tb_ordy = 1'b1;
        #1;
        check("bp.release", 64'(cur_ready), 64'd1);
        @(posedge clk);
        #1;
        tb_valid = 1'b0;
        @(negedge clk);
        check("bp.xor", cur_out, 64'h0F);
        check("bp.xor_valid", 64'(cur_valid), 64'd1);

        // Back-to-back single-cycle ops: one result per cycle
        sent = 0; recv = 0;
        for (int cyc = 0; cyc < 60 && recv < 16; cyc++) begin
            @(negedge clk);
            if (q_res.size() != 0) begin
                exp_res = q_res.pop_front();
                exp_flg = q_flg.pop_front();
                check("stream.valid", 64'(cur_valid), 64'd1);
                check("stream.out", cur_out, exp_res);
                check("stream.flags", 64'({cur_dz, cur_v, cur_c, cur_z}), 64'(exp_flg));
                recv++;
            end
            if (sent < 16) begin
                op = one_cyc[$urandom_range(0, 8)];
                a = rand_opnd(32);
                b = rand_opnd(32);
                model(32, op, a, b, er, ez, ec, ev, edz, elat);
                tb_op = op; tb_a = a; tb_b = b; tb_valid = 1'b1;
                check("stream.ready", 64'(cur_ready), 64'd1);
                q_res.push_back(er);
                q_flg.push_back({edz, ev, ec, ez});
                sent++;
            end else begin
                tb_valid = 1'b0;
            end
        end
        check("stream.count", 64'(recv), 64'd16);

        // Random WIDTH=32
        for (int i = 0; i < 50; i++) begin
            op = ($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(0, 11));
            run_op("rnd32", op, rand_opnd(32), rand_opnd(32));
        end

        // WIDTH=8
        sel8 = 1'b1;
        run_op("div8", OpDiv, 64'd200, 64'd3);
        expect_obs("div8", 64'd66, 0, 0, 0, 0, 9);

        @(negedge clk);
        tb_op = OpMul; tb_a = 64'd13; tb_b = 64'd11; tb_valid = 1'b1; tb_ordy = 1'b1;
        @(posedge clk);
        #1;
        tb_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst8.ready_in_rst", 64'(cur_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst8.valid", 64'(cur_valid), 64'd0);
        check("rst8.ready", 64'(cur_ready), 64'd1);
        check("rst8.out", cur_out, 64'd0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (cur_valid) seen++;
        end
        check("rst8.no_stale", 64'(seen), 64'd0);

        for (int i = 0; i < 40; i++) begin
            op = ($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(0, 11));
            run_op("rnd8", op, rand_opnd(8), rand_opnd(8));
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
